// File: rtl/wb_write_buffer.sv
// Write-back buffer: queues register-file writes until the shared bank port is free.
// Optional operand bypass lookup is enabled by defining WB_BYPASS_EN.
module wb_write_buffer #(
  parameter int R_DATA_WIDTH   = 32,
  parameter int REG_ADDR_WIDTH = 6,
  parameter int WARP_ID_WIDTH  = 5,
  parameter int DEPTH          = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_wb,
  input  logic                       rwe_wb,
  input  logic [R_DATA_WIDTH-1:0]    rdata_wb,
  input  logic [REG_ADDR_WIDTH-1:0]  raddr_wb,
  input  logic [WARP_ID_WIDTH-1:0]   wid_wb,
  output logic                       ready_wb,
  input  logic                       rf_rd_busy,
  output logic                       rf_we,
  output logic [REG_ADDR_WIDTH-1:0]  rf_waddr,
  output logic [WARP_ID_WIDTH-1:0]   rf_wwarp,
  output logic [R_DATA_WIDTH-1:0]    rf_wdata,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [REG_ADDR_WIDTH-1:0]  rd_addr,
  input  logic [WARP_ID_WIDTH-1:0]   rd_warp,
  output logic                       byp_hit,
  output logic [R_DATA_WIDTH-1:0]    byp_data
);

  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [R_DATA_WIDTH-1:0]   data_mem [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [WARP_ID_WIDTH-1:0]  warp_mem [DEPTH];
  logic [PTR_WIDTH-1:0]      wr_ptr;
  logic [PTR_WIDTH-1:0]      rd_ptr;
  logic                      enq;
  logic                      deq;

  assign ready_wb = (count != CNT_WIDTH'(DEPTH));
  assign enq      = valid_wb & rwe_wb & ready_wb;
  assign deq      = (count != '0) & ~rf_rd_busy;

  // Operand reads own the bank port; the head drains only on idle cycles.
  assign rf_we    = deq;
  assign rf_waddr = addr_mem[rd_ptr];
  assign rf_wwarp = warp_mem[rd_ptr];
  assign rf_wdata = data_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
        warp_mem[i] <= '0;
      end
    end else begin
      if (enq) begin
        data_mem[wr_ptr] <= rdata_wb;
        addr_mem[wr_ptr] <= raddr_wb;
        warp_mem[wr_ptr] <= wid_wb;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  logic [PTR_WIDTH-1:0] idx;

  // Scan oldest to youngest so the last match seen is the youngest entry.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_WIDTH'(k);
      if ((CNT_WIDTH'(k) < count) && (warp_mem[idx] == rd_warp) &&
          (addr_mem[idx] == rd_addr)) begin
        byp_hit  = 1'b1;
        byp_data = data_mem[idx];
      end
    end
  end
`else
  logic unused_lookup;

  assign unused_lookup = ^{rd_addr, rd_warp};
  assign byp_hit       = 1'b0;
  assign byp_data      = '0;
`endif

endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed bench for wb_write_buffer: a scoreboard queue holds expected register-file
// writes, popped by a monitor whenever rf_we is seen. Bypass expectations follow WB_BYPASS_EN.
module tb_wb_write_buffer;
  localparam int RD = 32;
  localparam int RA = 6;
  localparam int WI = 5;
  localparam int DP = 4;
  localparam int EW = WI + RA + RD;

  logic            clk;
  logic            rst;
  logic            valid_wb;
  logic            rwe_wb;
  logic [RD-1:0]   rdata_wb;
  logic [RA-1:0]   raddr_wb;
  logic [WI-1:0]   wid_wb;
  logic            ready_wb;
  logic            rf_rd_busy;
  logic            rf_we;
  logic [RA-1:0]   rf_waddr;
  logic [WI-1:0]   rf_wwarp;
  logic [RD-1:0]   rf_wdata;
  logic [2:0]      count;
  logic [RA-1:0]   rd_addr;
  logic [WI-1:0]   rd_warp;
  logic            byp_hit;
  logic [RD-1:0]   byp_data;

  logic [EW-1:0]   exp_q[$];
  int              checks = 0;
  int              errors = 0;

  wb_write_buffer #(
    .R_DATA_WIDTH(RD), .REG_ADDR_WIDTH(RA), .WARP_ID_WIDTH(WI), .DEPTH(DP)
  ) dut (
    .clk(clk), .rst(rst), .valid_wb(valid_wb), .rwe_wb(rwe_wb),
    .rdata_wb(rdata_wb), .raddr_wb(raddr_wb), .wid_wb(wid_wb),
    .ready_wb(ready_wb), .rf_rd_busy(rf_rd_busy), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wwarp(rf_wwarp), .rf_wdata(rf_wdata),
    .count(count), .rd_addr(rd_addr), .rd_warp(rd_warp),
    .byp_hit(byp_hit), .byp_data(byp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic v, input logic we, input logic [WI-1:0] w,
                               input logic [RA-1:0] a, input logic [RD-1:0] d,
                               input logic busy, input logic accept);
    @(posedge clk);
    #1;
    valid_wb   = v;
    rwe_wb     = we;
    wid_wb     = w;
    raddr_wb   = a;
    rdata_wb   = d;
    rf_rd_busy = busy;
    if (v && we && accept) exp_q.push_back({w, a, d});
    @(negedge clk);
  endtask

  // Every observed write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_write observed=%0h expected=none",
               {rf_wwarp, rf_waddr, rf_wdata});
      end
      if (exp_q.size() != 0) begin
        checkOutput("rf_write", 64'({rf_wwarp, rf_waddr, rf_wdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic exp_byp;
    exp_byp    = 1'b0;
`ifdef WB_BYPASS_EN
    exp_byp    = 1'b1;
`endif
    rst        = 1'b0;
    valid_wb   = 1'b0;
    rwe_wb     = 1'b0;
    rdata_wb   = '0;
    raddr_wb   = '0;
    wid_wb     = '0;
    rf_rd_busy = 1'b0;
    rd_addr    = '0;
    rd_warp    = '0;
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_ready", 64'(ready_wb), 64'd1);
    checkOutput("reset_rf_we", 64'(rf_we), 64'd0);
    checkOutput("reset_byp_hit", 64'(byp_hit), 64'd0);
    checkOutput("reset_waddr", 64'({rf_wwarp, rf_waddr, rf_wdata}), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] single enqueue");
    applyStimulus(1, 1, 5'd3, 6'd5, 32'hDEADBEEF, 0, 1);
    checkOutput("t1_ready", 64'(ready_wb), 64'd1);
    checkOutput("t1_no_passthru", 64'(rf_we), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_count1", 64'(count), 64'd1);
    checkOutput("t1_rf_we", 64'(rf_we), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_count0", 64'(count), 64'd0);
    checkOutput("t1_idle_we", 64'(rf_we), 64'd0);

    $display("[TB] fill while port busy");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, WI'(i), RA'(i + 8), 32'hA0000000 + i, 1, i < 4);
      checkOutput("t2_ready", 64'(ready_wb), 64'(i < 4));
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("t2_full_count", 64'(count), 64'd4);
    checkOutput("t2_busy_we", 64'(rf_we), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t2_drain_count", 64'(count), 64'(4 - i));
      checkOutput("t2_drain_we", 64'(rf_we), 64'd1);
      if (i == 0) checkOutput("t2_full_deq_ready", 64'(ready_wb), 64'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_empty", 64'(count), 64'd0);

    $display("[TB] discard without write enable");
    applyStimulus(1, 0, 5'd2, 6'd3, 32'h12345678, 0, 0);
    applyStimulus(1, 0, 5'd2, 6'd4, 32'h87654321, 0, 0);
    checkOutput("t3_count", 64'(count), 64'd0);
    checkOutput("t3_rf_we", 64'(rf_we), 64'd0);

    $display("[TB] simultaneous enqueue and dequeue across wrap");
    applyStimulus(1, 1, 5'd1, 6'd1, 32'hB0000001, 1, 1);
    applyStimulus(1, 1, 5'd1, 6'd2, 32'hB0000002, 1, 1);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1, 1, 5'd1, RA'(j + 3), 32'hB0000003 + j, 0, 1);
      checkOutput("t4_count", 64'(count), 64'd2);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_drain2", 64'(count), 64'd2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_drain1", 64'(count), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_drain0", 64'(count), 64'd0);

    $display("[TB] bypass lookup");
    applyStimulus(1, 1, 5'd0, 6'd7, 32'h11, 1, 1);
    applyStimulus(1, 1, 5'd0, 6'd7, 32'h22, 1, 1);
    applyStimulus(1, 1, 5'd1, 6'd7, 32'h33, 1, 1);
    rd_warp = 5'd0;
    rd_addr = 6'd7;
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("t5_hit_w0", 64'(byp_hit), 64'(exp_byp));
    checkOutput("t5_data_w0", 64'(byp_data), exp_byp ? 64'h22 : 64'h0);
    rd_warp = 5'd1;
    #1;
    checkOutput("t5_hit_w1", 64'(byp_hit), 64'(exp_byp));
    checkOutput("t5_data_w1", 64'(byp_data), exp_byp ? 64'h33 : 64'h0);
    rd_warp = 5'd2;
    rd_addr = 6'd9;
    #1;
    checkOutput("t5_miss", 64'(byp_hit), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_empty", 64'(count), 64'd0);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 5'd4, RA'(20 + i), 32'hC0 + i, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("t6_count3", 64'(count), 64'd3);
    #2;
    rst        = 1'b1;
    rf_rd_busy = 1'b0;
    #1;
    checkOutput("t6_rst_count", 64'(count), 64'd0);
    checkOutput("t6_rst_we", 64'(rf_we), 64'd0);
    checkOutput("t6_rst_ready", 64'(ready_wb), 64'd1);
    checkOutput("t6_rst_storage", 64'({rf_wwarp, rf_waddr, rf_wdata}), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t6_post_we", 64'(rf_we), 64'd0);
      checkOutput("t6_post_count", 64'(count), 64'd0);
    end

    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
